i2c_master_ctrl: RTL
====================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter: CLK_DIV, default 4, number of CLK cycles per SCL quarter-period (legal range 2..255).
REQ-002 CLK  input  1  system clock; all flops on rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a transaction; ignored while busy=1.
REQ-005 slave_addr  input  7  target address; sampled on the accepted start cycle.
REQ-006 rw  input  1  0=write, 1=read; sampled on the accepted start cycle.
REQ-007 num_bytes  input  4  data byte count 0..15; sampled on the accepted start cycle; 0 means address-only probe.
REQ-008 tx_data  input  8  write byte, latched when tx_ready pulses.
REQ-009 tx_ready  output  1  one-cycle pulse: tx_data latched for the next write byte.
REQ-010 rx_data  output  8  last received read byte; holds until the next read byte completes.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 busy  output  1  high from the cycle after the accepted start through the end of STOP.
REQ-013 done  output  1  one-cycle pulse on return to IDLE.
REQ-014 nack_err  output  1  set when the slave NACKs; cleared on the next accepted start.
REQ-015 SCL  output  1  I2C clock, idle high.
REQ-016 SDA  inout  1  open-drain data: driven 0 or high-Z only, never driven 1.

Function
REQ-017 A quarter-phase counter shall divide CLK by CLK_DIV; each SCL bit period shall have four phases Q0..Q3, with SCL low in Q0/Q1 and high in Q2/Q3.
REQ-018 SDA shall change only at the Q0 entry, except for START and STOP, and shall be sampled at the Q2 entry.
REQ-019 States shall be IDLE, START, ADDR, ADDR_ACK, WRITE, WACK, READ, RACK, STOP.
REQ-020 IDLE -> START on an accepted start; START shall pull SDA low while SCL is high for one full bit period.
REQ-021 ADDR shall shift out {slave_addr, rw} MSB first, 8 bits; ADDR_ACK shall release SDA and sample the slave response.
REQ-022 ADDR_ACK with SDA=1: set nack_err and go to STOP; with ACK and num_bytes=0: go to STOP; otherwise go to WRITE if rw=0, or READ if rw=1.
REQ-023 WRITE shall pulse tx_ready on the cycle it latches tx_data, one cycle before the first bit's Q0, then shift 8 bits MSB first; WACK shall sample ACK.
REQ-024 WACK NACK -> STOP with nack_err=1 and no further bytes sent; WACK ACK -> WRITE if bytes remain, otherwise STOP.
REQ-025 READ shall release SDA and shift in 8 bits MSB first; rx_data/rx_valid shall update at the Q2 sample of bit 0.
REQ-026 RACK shall drive ACK (0) if bytes remain and NACK (released) on the last byte, then go to READ or STOP.
REQ-027 STOP shall hold SDA low with SCL low, raise SCL, then release SDA while SCL is high; it shall then go to IDLE and pulse done.
REQ-028 Byte and bit counters shall be 4 and 3 bits wide and shall not wrap past their terminal counts.
REQ-029 A start asserted in the same cycle as done shall be ignored; it is accepted only while in IDLE.

Reset
REQ-030 RST low shall immediately force IDLE, SCL=1, SDA released, busy=0, done=0, tx_ready=0, rx_valid=0, nack_err=0, rx_data=0, and all counters=0.
REQ-031 Reset mid-transaction shall abort without generating STOP; the bus shall be left released.

Structure
REQ-032 Package i2c_pkg shall hold the state enumeration, the phase enumeration Q0..Q3, and the CLK_DIV default.
REQ-033 One sub-module, i2c_phase_gen, shall produce the quarter-phase strobes from CLK/RST/CLK_DIV; all else shall live in i2c_master_ctrl.

Verification
REQ-034 Write 0x5B, 2 bytes {0x55,0xD5}, slave ACKs all -> SDA sequence S,1011011,0,A,01010101,A,11010101,A,P; 2 tx_ready pulses; done; nack_err=0.
REQ-035 Read 0x20, 3 bytes, slave returns 0xA0,0x0F,0xFF -> three rx_valid pulses with those values; master ACK,ACK,NACK; then STOP.
REQ-036 Address 0x7F with no slave (SDA pulled up) -> nack_err=1 after ADDR_ACK; STOP; done; zero tx_ready pulses.
REQ-037 num_bytes=0 probe to 0x5B with ACK -> S, address byte, A, P only; done; nack_err=0.
REQ-038 RST low during the 4th data bit of a write -> SCL=1 and SDA released in the same cycle; busy=0; no done pulse.
REQ-039 start pulsed while busy, and again in the done cycle -> both ignored; exactly one transaction; CLK_DIV=4 gives an SCL period of 16 CLK.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the I2C master: controller states, SCL quarter phases
// and the default clock divider.
package i2c_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 4;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WACK,
        READ,
        RACK,
        STOP
    } state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } phase_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            Q0:      return Q1;
            Q1:      return Q2;
            Q2:      return Q3;
            default: return Q0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase generator: divides CLK by CLK_DIV and steps Q0..Q3.
// tick marks the last CLK cycle of the current phase; held at Q0 while disabled.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
)
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   en,
    output phase_e phase,
    output logic   tick
);

    logic [7:0] cnt_q, cnt_d;
    phase_e     phase_q, phase_d;

    assign tick  = en && (cnt_q == 8'(CLK_DIV - 1));
    assign phase = phase_q;

    always_comb begin
        cnt_d   = cnt_q + 8'd1;
        phase_d = phase_q;
        if (!en) begin
            cnt_d   = '0;
            phase_d = Q0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = next_phase(phase_q);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: START, 7-bit address + R/W, up to 15 data
// bytes with ACK handling, STOP. SDA is open-drain (driven low or released).
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
)
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic       rw,
    input  logic [3:0] num_bytes,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic       SCL,
    inout  wire        SDA
);

    state_e     state_q, state_d;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] byte_cnt_q, byte_cnt_d;
    logic [3:0] num_q, num_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       nack_err_q, nack_err_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    phase_e     phase;
    logic       tick;
    logic       bit_end;
    logic       sample;
    logic       sda_in;
    logic       bytes_left;
    logic [3:0] byte_inc;

    i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase_gen (
        .CLK   (CLK),
        .RST   (RST),
        .en    (state_q != IDLE),
        .phase (phase),
        .tick  (tick)
    );

    assign SDA    = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in = SDA;

    // bit_end: next cycle is Q0 of the next bit; sample: next cycle is Q2
    assign bit_end    = tick && (phase == Q3);
    assign sample     = tick && (phase == Q1);
    assign bytes_left = ({1'b0, byte_cnt_q} + 5'd1) < {1'b0, num_q};
    assign byte_inc   = (byte_cnt_q == 4'hF) ? byte_cnt_q : byte_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        scl_d      = scl_q;
        sda_oe_d   = sda_oe_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        num_d      = num_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_err_d = nack_err_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready   = 1'b0;

        // SCL stays high through START and after the rising edge in STOP
        if (sample) begin
            scl_d = 1'b1;
        end else if (bit_end && state_q != STOP) begin
            scl_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d    = START;
                    busy_d     = 1'b1;
                    sda_oe_d   = 1'b1;
                    shift_d    = {slave_addr, rw};
                    rw_d       = rw;
                    num_d      = num_bytes;
                    nack_err_d = 1'b0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = ADDR;
                    sda_oe_d = ~shift_q[7];
                end
            end
            ADDR, WRITE: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d  = (state_q == ADDR) ? ADDR_ACK : WACK;
                        sda_oe_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_oe_d  = ~shift_q[6];
                    end
                end
            end
            ADDR_ACK, WACK: begin
                if (sample) begin
                    ack_d = sda_in;
                end
                if (bit_end) begin
                    if (state_q == WACK && !ack_q) begin
                        byte_cnt_d = byte_inc;
                    end
                    if (ack_q) begin
                        nack_err_d = 1'b1;
                        state_d    = STOP;
                        sda_oe_d   = 1'b1;
                    end else if ((state_q == ADDR_ACK && num_q == 4'd0) ||
                                 (state_q == WACK && !bytes_left)) begin
                        state_d  = STOP;
                        sda_oe_d = 1'b1;
                    end else if (!rw_q) begin
                        // tx_data is latched on this edge, one cycle before Q0
                        state_d   = WRITE;
                        tx_ready  = 1'b1;
                        shift_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = READ;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
            end
            READ: begin
                if (sample) begin
                    shift_d = {shift_q[6:0], sda_in};
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {shift_q[6:0], sda_in};
                        rx_valid_d = 1'b1;
                    end
                end
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d  = RACK;
                        sda_oe_d = bytes_left;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            RACK: begin
                if (bit_end) begin
                    byte_cnt_d = byte_inc;
                    if (bytes_left) begin
                        state_d   = READ;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d  = STOP;
                        sda_oe_d = 1'b1;
                    end
                end
            end
            STOP: begin
                // SDA rises while SCL is high: the STOP condition
                if (tick && phase == Q2) begin
                    sda_oe_d = 1'b0;
                end
                if (bit_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            num_q      <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_err_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            num_q      <= num_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_err_q <= nack_err_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign SCL      = scl_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nack_err = nack_err_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
